// File: rtl/cnt10_pkg.sv
// Shared types and constants for the CNT10 sequencing controller.
package cnt10_pkg;

  localparam int WRAP_W_DEF = 8;
  localparam logic [3:0] DEC_MAX = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/cnt10_evt_cnt.sv
// Saturating event counter with clear and a
// hit flag for the increment that reaches lim.
module cnt10_evt_cnt #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] lim,
  output logic         hit
);

  logic [W-1:0] cnt;
  logic [W-1:0] nxt;

  assign nxt = (&cnt) ? cnt : cnt + 1'b1;
  assign hit = inc & (nxt == lim);

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= nxt;
    end
  end

endmodule

// File: rtl/cnt10_seq_ctrl.sv
// Sequencer: preload CNT10, run for a number of
// carry events, then stop and report the digit.
module cnt10_seq_ctrl
  import cnt10_pkg::*;
#(
  parameter int WRAP_W = WRAP_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [3:0]        preset,
  input  logic [WRAP_W-1:0] nwrap,
  input  logic              pause,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [7:0]        result,
  output logic              cnt_en,
  output logic              cnt_load_n,
  output logic [7:0]        cnt_data,
  input  logic              cnt_cout,
  input  logic [7:0]        cnt_dout
);

  state_t            state;
  logic [3:0]        preset_r;
  logic [WRAP_W-1:0] nwrap_r;
  logic              accept;
  logic              wrap_inc;
  logic              wrap_hit;

  assign accept   = (state == S_IDLE) & start
                  & (preset <= DEC_MAX);
  assign wrap_inc = (state == S_RUN) & ~pause
                  & cnt_cout;

  assign busy       = (state != S_IDLE);
  assign done       = (state == S_DONE);
  assign cnt_load_n = (state != S_LOAD);
  assign cnt_en     = (state == S_RUN) & ~pause;
  assign cnt_data   = {4'b0, preset_r};

  cnt10_evt_cnt #(
    .W(WRAP_W)
  ) u_wrap (
    .clk(clk),
    .rst(rst),
    .clr(accept),
    .inc(wrap_inc),
    .lim(nwrap_r),
    .hit(wrap_hit)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      preset_r <= '0;
      nwrap_r  <= '0;
      err      <= 1'b0;
      result   <= '0;
    end else begin
      err <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            preset_r <= preset;
            nwrap_r  <= nwrap;
            state    <= S_LOAD;
          end else if (start) begin
            err <= 1'b1;
          end
        end
        S_LOAD: begin
          if (abort)
            state <= S_IDLE;
          else if (nwrap_r == '0)
            state <= S_DONE;
          else
            state <= S_RUN;
        end
        S_RUN: begin
          if (abort)
            state <= S_IDLE;
          else if (wrap_hit)
            state <= S_DONE;
        end
        S_DONE: begin
          // an abort here still returns to idle,
          // but the digit is not reported
          if (!abort)
            result <= cnt_dout;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cnt10_seq_ctrl.sv
// Directed bench: controller plus a small
// behavioural CNT10 decimal counter.
module tb_cnt10_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] preset;
  logic [7:0] nwrap;
  logic       pause;
  logic       abort;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] result;
  logic       cnt_en;
  logic       cnt_load_n;
  logic [7:0] cnt_data;
  logic       cnt_cout;
  logic [7:0] cnt_dout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cnt10_seq_ctrl #(.WRAP_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .preset(preset),
    .nwrap(nwrap),
    .pause(pause),
    .abort(abort),
    .busy(busy),
    .done(done),
    .err(err),
    .result(result),
    .cnt_en(cnt_en),
    .cnt_load_n(cnt_load_n),
    .cnt_data(cnt_data),
    .cnt_cout(cnt_cout),
    .cnt_dout(cnt_dout)
  );

  // CNT10 model: load wins, then count 0..9
  assign cnt_cout = cnt_en & (cnt_dout == 8'd9);
  always_ff @(posedge clk) begin
    if (!rst)
      cnt_dout <= 8'd0;
    else if (!cnt_load_n)
      cnt_dout <= cnt_data;
    else if (cnt_en)
      cnt_dout <= (cnt_dout == 8'd9) ? 8'd0
                : cnt_dout + 8'd1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  int n, en_n, busy_n, done_n, ld_n;
  int r, done_at;
  logic       prev_p;
  logic [7:0] prev_d;

  initial begin
    rst = 1'b0; start = 1'b0; preset = '0;
    nwrap = '0; pause = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_result", result, 0);
    chk("rst_en", cnt_en, 0);
    chk("rst_load_n", cnt_load_n, 1);
    chk("rst_data", cnt_data, 0);
    rst = 1'b1;
    tick();
    chk("idle_busy", busy, 0);

    // preset 7, two wraps
    preset = 4'd7; nwrap = 8'd2; start = 1'b1;
    tick();
    start = 1'b0;
    chk("a_load_n", cnt_load_n, 0);
    chk("a_data", cnt_data, 8'd7);
    busy_n = 1; en_n = 0; done_n = 0; ld_n = 0; n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
      if (busy) busy_n++;
      if (cnt_en) en_n++;
      if (!cnt_load_n) ld_n++;
      if (done) begin
        done_n++;
        chk("a_done_dout", cnt_dout, 8'd0);
      end
    end
    chk("a_timeout", busy, 0);
    chk("a_en_cycles", en_n, 13);
    chk("a_busy_cycles", busy_n, 15);
    chk("a_done_pulses", done_n, 1);
    chk("a_extra_load", ld_n, 0);
    chk("a_result", result, 8'h00);

    // illegal preset
    preset = 4'hA; nwrap = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("b_err", err, 1);
    chk("b_busy", busy, 0);
    chk("b_load_n", cnt_load_n, 1);
    chk("b_data_kept", cnt_data, 8'd7);
    tick();
    chk("b_err_drop", err, 0);
    chk("b_busy2", busy, 0);

    // preset 0, one wrap, pause 4 cycles
    preset = 4'd0; nwrap = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    r = 0; done_at = 0; en_n = 0; prev_p = 1'b0;
    prev_d = cnt_dout;
    while (busy && r < 40) begin
      tick();
      r++;
      pause = (r >= 3 && r <= 6);
      #1;
      if (prev_p)
        chk("d_frozen", cnt_dout, prev_d);
      if (cnt_en) en_n++;
      if (done && done_at == 0) done_at = r;
      prev_p = pause;
      prev_d = cnt_dout;
    end
    pause = 1'b0;
    chk("d_timeout", busy, 0);
    chk("d_done_at", done_at, 15);
    chk("d_en_cycles", en_n, 10);
    chk("d_result", result, 8'h00);

    // preset 3, zero wraps
    preset = 4'd3; nwrap = 8'd0; start = 1'b1;
    tick();
    start = 1'b0;
    chk("c_load_n", cnt_load_n, 0);
    chk("c_en_load", cnt_en, 0);
    tick();
    chk("c_done", done, 1);
    chk("c_en_done", cnt_en, 0);
    tick();
    chk("c_idle", busy, 0);
    chk("c_done_drop", done, 0);
    chk("c_result", result, 8'h03);

    // preset 5, three wraps, abort in run 6
    preset = 4'd5; nwrap = 8'd3; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 3) begin
        preset = 4'd2; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (i == 4) begin
        chk("e_dout_r4", cnt_dout, 8'd8);
        chk("e_data_kept", cnt_data, 8'd5);
        chk("e_no_reload", cnt_load_n, 1);
      end
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("e_abort_busy", busy, 0);
    chk("e_abort_done", done, 0);
    chk("e_abort_en", cnt_en, 0);
    chk("e_result_kept", result, 8'h03);
    prev_d = cnt_dout;
    tick();
    tick();
    chk("e_still_idle", busy, 0);
    chk("e_dout_held", cnt_dout, prev_d);

    // reset mid-run
    preset = 4'd1; nwrap = 8'd1; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("f_running", cnt_en, 1);
    rst = 1'b0;
    tick();
    chk("f_busy", busy, 0);
    chk("f_en", cnt_en, 0);
    chk("f_load_n", cnt_load_n, 1);
    chk("f_result", result, 0);
    chk("f_data", cnt_data, 0);
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
